seg_scan_mux: RTL and testbench

- Consumes the 4-digit BCD/glyph output of the vending display path (digit3..digit0) and drives a time-multiplexed common-anode 4-digit seven-segment display.
- Scans one digit per slot and latches a coherent snapshot of all digits at each frame start, so a frame never mixes old and new digits.
- Inserts an inter-digit blanking guard against ghosting and applies optional leading-zero suppression.
- Sits between the display driver and the board pins.

---
 rtl/seg_scan_pkg.sv | 34 +++
 rtl/seg_scan_mux_decode.sv | 37 +++
 rtl/seg_scan_mux.sv | 158 +++++++++++++++
 tb/tb_seg_scan_mux.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
// -----------------------------------------------------------------------------
// seg_scan_pkg
// Shared constants for the seven-segment scan multiplexer.
//   NUM_DIGITS    number of scanned digits
//   SLOT_FIRST    slot index scanned first in a frame (leftmost digit)
//   GLYPH_0..F    active-high segment patterns, bit0 = a ... bit6 = g
// -----------------------------------------------------------------------------
package seg_scan_pkg;

  localparam int NUM_DIGITS = 4;

  typedef logic [1:0] slot_t;

  localparam slot_t SLOT_FIRST = 2'd3;

  //                               gfedcba
  localparam logic [6:0] GLYPH_0 = 7'b0111111;
  localparam logic [6:0] GLYPH_1 = 7'b0000110;
  localparam logic [6:0] GLYPH_2 = 7'b1011011;
  localparam logic [6:0] GLYPH_3 = 7'b1001111;
  localparam logic [6:0] GLYPH_4 = 7'b1100110;
  localparam logic [6:0] GLYPH_5 = 7'b1101101;
  localparam logic [6:0] GLYPH_6 = 7'b1111101;
  localparam logic [6:0] GLYPH_7 = 7'b0000111;
  localparam logic [6:0] GLYPH_8 = 7'b1111111;
  localparam logic [6:0] GLYPH_9 = 7'b1101111;
  localparam logic [6:0] GLYPH_A = 7'b1110111;
  localparam logic [6:0] GLYPH_B = 7'b1111100;
  localparam logic [6:0] GLYPH_C = 7'b0111001;
  localparam logic [6:0] GLYPH_D = 7'b1011110;
  localparam logic [6:0] GLYPH_E = 7'b1111001;
  localparam logic [6:0] GLYPH_F = 7'b1110001;

endpackage

// File: rtl/seg_scan_mux_decode.sv
// -----------------------------------------------------------------------------
// seg7_decode
// Combinational hex glyph decoder. Output is active-high; pin polarity is
// applied by the scanner.
//   i_code  4-bit glyph code
//   o_seg   7-bit segments, bit0 = a ... bit6 = g, 1 = lit
// -----------------------------------------------------------------------------
module seg7_decode
  import seg_scan_pkg::*;
(
  input  logic [3:0] i_code,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = GLYPH_0;
    case (i_code)
      4'h0: o_seg = GLYPH_0;
      4'h1: o_seg = GLYPH_1;
      4'h2: o_seg = GLYPH_2;
      4'h3: o_seg = GLYPH_3;
      4'h4: o_seg = GLYPH_4;
      4'h5: o_seg = GLYPH_5;
      4'h6: o_seg = GLYPH_6;
      4'h7: o_seg = GLYPH_7;
      4'h8: o_seg = GLYPH_8;
      4'h9: o_seg = GLYPH_9;
      4'hA: o_seg = GLYPH_A;
      4'hB: o_seg = GLYPH_B;
      4'hC: o_seg = GLYPH_C;
      4'hD: o_seg = GLYPH_D;
      4'hE: o_seg = GLYPH_E;
      4'hF: o_seg = GLYPH_F;
    endcase
  end

endmodule

// File: rtl/seg_scan_mux.sv
// -----------------------------------------------------------------------------
// seg_scan_mux
// Time-multiplexed driver for a common-anode 4-digit seven-segment display.
// One digit per slot of REFRESH_DIV cycles, scanned digit3 -> digit0. All
// digit inputs are snapshotted at frame start so a frame never mixes old and
// new values. Each slot opens with BLANK_CYCLES of all-anodes-off to avoid
// ghosting. REFRESH_DIV must exceed BLANK_CYCLES + 1.
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   enable       scan enable; low blanks outputs and parks at frame start
//   digit3..0    glyph codes, digit3 leftmost
//   dp_mask      decimal point per digit (bit n -> digitn)
//   lz_suppress  leading-zero suppression enable
//   seg          segments a..g (seg[0] = a)
//   dp           decimal point
//   an           anode select (an[n] -> digitn)
//   frame_done   one-cycle pulse after the last cycle of a frame
// -----------------------------------------------------------------------------
module seg_scan_mux
  import seg_scan_pkg::*;
#(
  parameter int REFRESH_DIV    = 1000,
  parameter int BLANK_CYCLES   = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [3:0] digit3,
  input  logic [3:0] digit2,
  input  logic [3:0] digit1,
  input  logic [3:0] digit0,
  input  logic [3:0] dp_mask,
  input  logic       lz_suppress,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       frame_done
);

  localparam int               DIV_W     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(REFRESH_DIV - 1);
  localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK_CYCLES);
  localparam logic [6:0]       SEG_OFF   = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic             DP_OFF    = SEG_ACTIVE_LOW;
  localparam logic [3:0]       AN_OFF    = AN_ACTIVE_LOW ? 4'hF : 4'h0;

  logic [DIV_W-1:0]                r_div_cnt;
  slot_t                           r_slot;
  logic [NUM_DIGITS-1:0][3:0]      r_digit;
  logic [NUM_DIGITS-1:0]           r_dp_mask;
  logic                            r_lz;
  logic [6:0]                      r_seg;
  logic                            r_dp;
  logic [3:0]                      r_an;
  logic                            r_frame_done;

  logic                            w_frame_start;
  logic                            w_slot_end;
  logic                            w_drive;
  logic [NUM_DIGITS-1:0][3:0]      w_digit;
  logic [NUM_DIGITS-1:0]           w_dp_mask;
  logic                            w_lz;
  logic [NUM_DIGITS-1:0]           w_blank;
  logic [3:0]                      w_code;
  logic [6:0]                      w_glyph;
  logic [6:0]                      w_seg_hi;
  logic [3:0]                      w_an_hi;
  logic                            w_dp_hi;

  assign w_frame_start = enable && (r_slot == SLOT_FIRST) && (r_div_cnt == '0);
  assign w_slot_end    = (r_div_cnt == DIV_LAST);
  assign w_drive       = (r_div_cnt >= BLANK_END);

  // During the frame-start cycle the shadow is still being loaded; look
  // through to the inputs so a zero-length blank window shows the new frame.
  assign w_digit   = w_frame_start ? {digit3, digit2, digit1, digit0} : r_digit;
  assign w_dp_mask = w_frame_start ? dp_mask : r_dp_mask;
  assign w_lz      = w_frame_start ? lz_suppress : r_lz;

  // Suppression chains left to right; the rightmost digit always shows.
  assign w_blank[3] = w_lz && (w_digit[3] == 4'd0);
  assign w_blank[2] = w_blank[3] && (w_digit[2] == 4'd0);
  assign w_blank[1] = w_blank[2] && (w_digit[1] == 4'd0);
  assign w_blank[0] = 1'b0;

  assign w_code = w_digit[r_slot];

  seg7_decode u_decode (
    .i_code (w_code),
    .o_seg  (w_glyph)
  );

  always_comb begin
    w_seg_hi = w_glyph;
    if (w_blank[r_slot]) begin
      w_seg_hi = 7'h00;
    end
    w_an_hi = 4'b0001 << r_slot;
    w_dp_hi = w_dp_mask[r_slot];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt    <= '0;
      r_slot       <= SLOT_FIRST;
      r_digit      <= '0;
      r_dp_mask    <= '0;
      r_lz         <= 1'b0;
      r_seg        <= SEG_OFF;
      r_dp         <= DP_OFF;
      r_an         <= AN_OFF;
      r_frame_done <= 1'b0;
    end else if (!enable) begin
      // Shadow registers intentionally hold while disabled.
      r_div_cnt    <= '0;
      r_slot       <= SLOT_FIRST;
      r_seg        <= SEG_OFF;
      r_dp         <= DP_OFF;
      r_an         <= AN_OFF;
      r_frame_done <= 1'b0;
    end else begin
      if (w_frame_start) begin
        r_digit   <= {digit3, digit2, digit1, digit0};
        r_dp_mask <= dp_mask;
        r_lz      <= lz_suppress;
      end

      if (w_slot_end) begin
        r_div_cnt <= '0;
        r_slot    <= r_slot - 2'd1;
      end else begin
        r_div_cnt <= r_div_cnt + DIV_W'(1);
      end

      r_frame_done <= w_slot_end && (r_slot == 2'd0);

      if (w_drive) begin
        r_an  <= AN_ACTIVE_LOW  ? ~w_an_hi  : w_an_hi;
        r_seg <= SEG_ACTIVE_LOW ? ~w_seg_hi : w_seg_hi;
        r_dp  <= SEG_ACTIVE_LOW ? ~w_dp_hi  : w_dp_hi;
      end else begin
        r_an  <= AN_OFF;
        r_seg <= SEG_OFF;
        r_dp  <= DP_OFF;
      end
    end
  end

  // Async reset must force pins inactive without waiting for a clock; the
  // registers already reset asynchronously, so the pins follow directly.
  assign seg        = r_seg;
  assign dp         = r_dp;
  assign an         = r_an;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_mux.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_mux
// Scoreboard bench: each frame of stimulus pushes the expected per-slot pin
// state; a negedge monitor pops an entry at the start of every anode-active
// run and compares every cycle of the run, plus run length and frame period.
// -----------------------------------------------------------------------------
module tb_seg_scan_mux;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [3:0] digit3, digit2, digit1, digit0;
  logic [3:0] dp_mask;
  logic       lz_suppress;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       frame_done;

  seg_scan_mux #(
    .REFRESH_DIV    (8),
    .BLANK_CYCLES   (2),
    .SEG_ACTIVE_LOW (1'b1),
    .AN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .digit3      (digit3),
    .digit2      (digit2),
    .digit1      (digit1),
    .digit0      (digit0),
    .dp_mask     (dp_mask),
    .lz_suppress (lz_suppress),
    .seg         (seg),
    .dp          (dp),
    .an          (an),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic       dp;
    logic [6:0] seg;
    logic       full;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   n_chk = 0;
  int   n_err = 0;
  int   run_len = 0;
  bit   have_cur = 1'b0;
  bit   mon_on = 1'b0;
  int   cyc = 0;
  int   last_fd = 0;
  bit   fd_valid = 1'b0;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic push_slot(input int s, input logic [6:0] lit, input logic dpl, input bit full);
    exp_t       e;
    logic [3:0] oh;
    oh     = 4'b0001 << s;
    e.an   = ~oh;
    e.dp   = ~dpl;
    e.seg  = ~lit;
    e.full = full;
    exp_q.push_back(e);
  endtask

  task automatic set_inputs(input logic [3:0] d3, input logic [3:0] d2, input logic [3:0] d1,
                            input logic [3:0] d0, input logic [3:0] dpm, input logic lz);
    digit3      = d3;
    digit2      = d2;
    digit1      = d1;
    digit0      = d0;
    dp_mask     = dpm;
    lz_suppress = lz;
  endtask

  task automatic set_frame(input logic [3:0] d3, input logic [3:0] d2, input logic [3:0] d1,
                           input logic [3:0] d0, input logic [3:0] dpm, input logic lz,
                           input logic [6:0] e3, input logic [6:0] e2, input logic [6:0] e1,
                           input logic [6:0] e0);
    set_inputs(d3, d2, d1, d0, dpm, lz);
    push_slot(3, e3, dpm[3], 1'b1);
    push_slot(2, e2, dpm[2], 1'b1);
    push_slot(1, e1, dpm[1], 1'b1);
    push_slot(0, e0, dpm[0], 1'b1);
  endtask

  task automatic wait_fd();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_done !== 1'b1 && n < 100);
    chk_eq("fd_seen", {31'd0, frame_done}, 32'd1);
    chk_eq("fd_an", {28'd0, an}, 32'hE);
  endtask

  task automatic run_frame(input logic [3:0] d3, input logic [3:0] d2, input logic [3:0] d1,
                           input logic [3:0] d0, input logic [3:0] dpm, input logic lz,
                           input logic [6:0] e3, input logic [6:0] e2, input logic [6:0] e1,
                           input logic [6:0] e0);
    set_frame(d3, d2, d1, d0, dpm, lz, e3, e2, e1, e0);
    wait_fd();
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!mon_on) begin
      run_len  = 0;
      have_cur = 1'b0;
      fd_valid = 1'b0;
    end else begin
      if (an !== 4'hF) begin
        if (run_len == 0) begin
          if (exp_q.size() == 0) begin
            chk_eq("extra_drive", {28'd0, an}, 32'hF);
            have_cur = 1'b0;
          end else begin
            cur      = exp_q.pop_front();
            have_cur = 1'b1;
          end
        end
        if (have_cur)
          chk_eq("drive", {20'd0, an, dp, seg}, {20'd0, cur.an, cur.dp, cur.seg});
        run_len++;
      end else if (run_len != 0) begin
        if (have_cur && cur.full) chk_eq("run_len", run_len, 32'd6);
        run_len  = 0;
        have_cur = 1'b0;
      end
      if (!enable) begin
        fd_valid = 1'b0;
      end else if (frame_done === 1'b1) begin
        if (fd_valid) chk_eq("fd_period", cyc - last_fd, 32'd32);
        fd_valid = 1'b1;
        last_fd  = cyc;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n  = 1'b0;
    enable = 1'b0;
    set_inputs(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);

    // Reset and idle
    repeat (3) @(negedge clk);
    chk_eq("rst_seg", {25'd0, seg}, 32'h7F);
    chk_eq("rst_dp", {31'd0, dp}, 32'd1);
    chk_eq("rst_an", {28'd0, an}, 32'hF);
    chk_eq("rst_fd", {31'd0, frame_done}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk_eq("idle", {19'd0, frame_done, dp, an, seg}, {19'd0, 1'b0, 1'b1, 4'hF, 7'h7F});
    end

    // Basic scan, two frames for the frame period
    mon_on = 1'b1;
    set_frame(4'h1, 4'h2, 4'h5, 4'h0, 4'b0000, 1'b0, 7'h06, 7'h5B, 7'h6D, 7'h3F);
    enable = 1'b1;
    wait_fd();
    run_frame(4'h1, 4'h2, 4'h5, 4'h0, 4'b0000, 1'b0, 7'h06, 7'h5B, 7'h6D, 7'h3F);

    // Leading-zero suppression
    run_frame(4'h0, 4'h0, 4'h5, 4'h0, 4'b1010, 1'b1, 7'h00, 7'h00, 7'h6D, 7'h3F);
    run_frame(4'h0, 4'h0, 4'h0, 4'h0, 4'b0000, 1'b1, 7'h00, 7'h00, 7'h00, 7'h3F);
    run_frame(4'h0, 4'h3, 4'h0, 4'h0, 4'b0000, 1'b1, 7'h00, 7'h4F, 7'h3F, 7'h3F);

    // Error/done glyphs and the rest of the hex table
    run_frame(4'hE, 4'hE, 4'h0, 4'h0, 4'b0000, 1'b0, 7'h79, 7'h79, 7'h3F, 7'h3F);
    run_frame(4'hD, 4'h0, 4'hE, 4'h0, 4'b0000, 1'b0, 7'h5E, 7'h3F, 7'h79, 7'h3F);
    run_frame(4'hA, 4'hB, 4'hC, 4'hF, 4'b1111, 1'b0, 7'h77, 7'h7C, 7'h39, 7'h71);
    run_frame(4'h3, 4'h4, 4'h6, 4'h7, 4'b0100, 1'b0, 7'h4F, 7'h66, 7'h7D, 7'h07);
    run_frame(4'h8, 4'h9, 4'h1, 4'h2, 4'b0000, 1'b1, 7'h7F, 7'h6F, 7'h06, 7'h5B);

    // Snapshot coherence: change inputs at slot 2, div_cnt 4
    set_frame(4'h1, 4'h2, 4'h3, 4'h4, 4'b0000, 1'b0, 7'h06, 7'h5B, 7'h4F, 7'h66);
    repeat (12) @(negedge clk);
    set_inputs(4'h9, 4'h8, 4'h7, 4'h6, 4'b0000, 1'b0);
    wait_fd();
    run_frame(4'h9, 4'h8, 4'h7, 4'h6, 4'b0000, 1'b0, 7'h6F, 7'h7F, 7'h07, 7'h7D);

    // Enable dropped during slot 1
    set_inputs(4'h5, 4'h5, 4'h5, 4'h5, 4'b0000, 1'b0);
    push_slot(3, 7'h6D, 1'b0, 1'b1);
    push_slot(2, 7'h6D, 1'b0, 1'b1);
    push_slot(1, 7'h6D, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk_eq("drop_out", {20'd0, an, dp, seg}, {20'd0, 4'hF, 1'b1, 7'h7F});
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk_eq("disabled", {27'd0, frame_done, an}, {27'd0, 1'b0, 4'hF});
    end

    // Re-enable restarts at slot 3 after two blank cycles
    set_frame(4'h4, 4'h3, 4'h2, 4'h1, 4'b0000, 1'b0, 7'h66, 7'h4F, 7'h5B, 7'h06);
    enable = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (an === 4'hF && n < 20);
    chk_eq("restart_lat", n, 32'd3);
    chk_eq("restart_an", {28'd0, an}, 32'h7);
    wait_fd();

    // Reset asserted mid-slot
    set_frame(4'h7, 4'h7, 4'h7, 4'h7, 4'b0000, 1'b0, 7'h07, 7'h07, 7'h07, 7'h07);
    repeat (4) @(negedge clk);
    mon_on = 1'b0;
    exp_q.delete();
    #2;
    rst_n = 1'b0;
    #1;
    chk_eq("rst_async", {19'd0, frame_done, dp, an, seg}, {19'd0, 1'b0, 1'b1, 4'hF, 7'h7F});
    repeat (2) @(negedge clk);
    chk_eq("rst_hold", {19'd0, frame_done, dp, an, seg}, {19'd0, 1'b0, 1'b1, 4'hF, 7'h7F});
    set_frame(4'h2, 4'h0, 4'h1, 4'h9, 4'b0001, 1'b1, 7'h5B, 7'h3F, 7'h06, 7'h6F);
    mon_on = 1'b1;
    rst_n  = 1'b1;
    wait_fd();
    repeat (3) @(negedge clk);
    mon_on = 1'b0;
    chk_eq("q_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
